dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back data cache with a blocking miss FSM, directly upstream of the mem writeback-select stage.
- Accepts load/store requests from the execute stage and returns a registered 128-bit line (cache_data) plus the registered word offset (line_out).
- Fills and evicts 128-bit lines over a single-outstanding memory port.
- Store widths use the same w_type encoding as the writeback-select stage.

Parameters:
- ADDR_W, 32, word-address width; bits [1:0] select one 32-bit word within a 128-bit line.
- SETS, 64, number of lines (power of two); INDEX_W = log2(SETS); TAG_W = ADDR_W - 2 - INDEX_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  cache can accept (IDLE only)
- req_addr  in  ADDR_W  word address
- req_wtype  in  2  00 read, 01 32-bit write, 10 36-bit write, 11 128-bit write
- req_wdata  in  128  store data, right-aligned for 32/36-bit writes
- resp_valid  out  1  cache_data/line_out valid this cycle
- cache_data  out  128  addressed line (post-merge for stores)
- line_out  out  2  req_addr[1:0] of the responded request
- stall  out  1  high while a miss is in progress
- mem_req  out  1  memory request
- mem_we  out  1  1 = line writeback, 0 = line fill
- mem_addr  out  ADDR_W  line-aligned address, bits [1:0] = 0
- mem_wdata  out  128  victim line
- mem_ready  in  1  memory accepted mem_req this cycle
- mem_rvalid  in  1  fill data valid
- mem_rdata  in  128  fill line

Behaviour:
- Reset (async, rst=0):
  - All valid and dirty bits cleared; state IDLE.
  - req_ready=1; resp_valid=0, stall=0, mem_req=0, mem_we=0.
  - cache_data=0, line_out=0, mem_addr=0, mem_wdata=0.
  - Reset mid-miss abandons the miss; the memory side is reset with the cache.
- Address split: tag=addr[ADDR_W-1:INDEX_W+2], index=addr[INDEX_W+1:2], offset=addr[1:0].
- Store merge into line L (o = offset):
  - 01: word o = wdata[31:0].
  - 10: bits [35:0] of 64-bit half o[1] = wdata[35:0]; the upper 28 bits of that half are unchanged.
  - 11: whole line = wdata.
  - Every store sets the line's dirty bit.
- IDLE:
  - req_ready=1. On req_valid, latch the request and compare tags.
  - Hit: next cycle resp_valid=1, cache_data = line after merge, line_out = offset. One-cycle latency, back-to-back hits at full rate.
  - Miss: stall=1, req_ready=0. Go to WB if the victim is valid and dirty, else REFILL.
- WB:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, 2'b00}, mem_wdata = victim line.
  - Hold all outputs until mem_ready, then go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {req tag, index, 2'b00}.
  - On mem_ready, drop mem_req and go to WAIT.
  - If mem_rvalid is high in the same cycle, take the fill immediately (as in WAIT).
- WAIT:
  - On mem_rvalid, write mem_rdata into the line with valid=1, dirty=0, tag updated, then go to RESPOND.
- RESPOND:
  - Replay the latched request as a hit, including the merge and dirty set for stores.
  - resp_valid=1 next cycle; stall=0; return to IDLE.
- Stores of width 11 also refill on a miss; this keeps the miss path uniform.
- resp_valid is a one-cycle pulse per accepted request; responses stay in order.
- No new request is accepted while stall=1.
- mem_rvalid outside WAIT/REFILL is ignored.

Decomposition:
- Package dcache_pkg:
  - w_type constants WT_READ=2'b00, WT_W32=2'b01, WT_W36=2'b10, WT_W128=2'b11.
  - State enum {IDLE, WB, REFILL, WAIT, RESPOND}.
  - Function merge_line(line, wdata, wtype, offset).
- Sub-module dcache_array: tag/valid/dirty/data storage.
  - One combinational read port and one write port.
  - Valid/dirty bits reset by rst; data and tags are not reset.

Test Plan:
- Cold read of addr 0x100 with memory returning line 0xAAAA..._0003_0002_0001_0000:
  - REFILL only, no WB; mem_addr=0x100.
  - resp_valid with cache_data = that line, line_out=0; a second read to 0x102 hits in 1 cycle with line_out=2.
- 32-bit write, data 0xDEADBEEF to 0x101 after the fill:
  - Response line has word1=0xDEADBEEF, other words unchanged; dirty=1.
- 36-bit write, data 0xF_1234_5678 to 0x103:
  - Bits [99:64] = 0xF12345678; bits [127:100] unchanged.
- Read 0x100+SETS*4, same index, while the line is dirty:
  - WB to mem_addr 0x100 with the merged line, then REFILL at 0x200; response correct.
- mem_ready held low 5 cycles in WB:
  - mem_req/mem_addr/mem_wdata stable, stall=1, req_ready=0 throughout.
- rst asserted during WAIT:
  - All outputs take reset values immediately.
  - A subsequent read of the same address misses (valid cleared) and never raises resp_valid before the new fill.

Source files
------------

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types, store-width encodings and the line merge
//                helper used by the data cache controller and its storage.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int LINE_W = 128;

    // Store widths, shared with the writeback-select stage
    localparam logic [1:0] WT_READ = 2'b00;
    localparam logic [1:0] WT_W32  = 2'b01;
    localparam logic [1:0] WT_W36  = 2'b10;
    localparam logic [1:0] WT_W128 = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB      = 3'd1,
        REFILL  = 3'd2,
        WAIT    = 3'd3,
        RESPOND = 3'd4
    } state_t;

    // Apply a store to a line. A 36-bit store lands in the low 36 bits of the
    // 64-bit half picked by offset[1]; the top 28 bits of that half survive.
    function automatic logic [LINE_W-1:0] merge_line(
        input logic [LINE_W-1:0] line,
        input logic [LINE_W-1:0] wdata,
        input logic [1:0]        wtype,
        input logic [1:0]        offset
    );
        logic [LINE_W-1:0] merged;
        merged = line;
        case (wtype)
            WT_W32:  merged[{offset, 5'b0} +: 32]    = wdata[31:0];
            WT_W36:  merged[{offset[1], 6'b0} +: 36] = wdata[35:0];
            WT_W128: merged = wdata;
            default: merged = line;
        endcase
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_array
//  Description : Tag / valid / dirty / data storage for a direct-mapped cache.
//                One combinational read port, one synchronous write port.
//                Only valid and dirty bits are reset.
//  Ports       : clk, rst (async, active-low)
//                rd_index -> rd_valid, rd_dirty, rd_tag, rd_data
//                wr_en, wr_index, wr_tag, wr_data, wr_dirty (write sets valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS    = 64,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_data,
    input  logic               wr_dirty
);

    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    assign rd_valid = r_valid[rd_index];
    assign rd_dirty = r_dirty[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_data  = r_data[rd_index];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (wr_en) begin
            r_valid[wr_index] <= 1'b1;
            r_dirty[wr_index] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_index]  <= wr_tag;
            r_data[wr_index] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped write-back data cache with a blocking miss FSM.
//  Ports       : clk, rst (async, active-low)
//                req_valid/req_ready/req_addr/req_wtype/req_wdata : request
//                resp_valid/cache_data/line_out                   : response
//                stall                                            : miss busy
//                mem_req/mem_we/mem_addr/mem_wdata/mem_ready      : mem cmd
//                mem_rvalid/mem_rdata                             : fill data
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SETS   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_wtype,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [LINE_W-1:0] cache_data,
    output logic [1:0]        line_out,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - 2 - INDEX_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_req_addr;
    logic [1:0]        r_req_wtype;
    logic [LINE_W-1:0] r_req_wdata;

    logic [ADDR_W-1:0]  w_addr;
    logic [1:0]         w_wtype;
    logic [LINE_W-1:0]  w_wdata;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_index;
    logic [1:0]         w_offset;
    logic               w_rd_valid;
    logic               w_rd_dirty;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [LINE_W-1:0]  w_rd_data;
    logic               w_hit;
    logic               w_is_store;
    logic               w_fill;
    logic [LINE_W-1:0]  w_merged;
    logic               w_wr_en;
    logic               w_wr_dirty;
    logic [LINE_W-1:0]  w_wr_data;

    // In IDLE the live request drives the lookup so a hit answers next cycle;
    // during a miss the latched request is replayed against the array.
    assign w_addr   = (r_state == IDLE) ? req_addr  : r_req_addr;
    assign w_wtype  = (r_state == IDLE) ? req_wtype : r_req_wtype;
    assign w_wdata  = (r_state == IDLE) ? req_wdata : r_req_wdata;
    assign w_tag    = w_addr[ADDR_W-1:INDEX_W+2];
    assign w_index  = w_addr[INDEX_W+1:2];
    assign w_offset = w_addr[1:0];

    assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
    assign w_is_store = (w_wtype != WT_READ);
    assign w_merged   = merge_line(w_rd_data, w_wdata, w_wtype, w_offset);
    assign w_fill     = ((r_state == WAIT) && mem_rvalid) ||
                        ((r_state == REFILL) && mem_ready && mem_rvalid);

    // Single write port: fills write the clean memory line, stores write the
    // merged line dirty. Both always set valid and the request tag.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_dirty = 1'b1;
        w_wr_data  = w_merged;
        if (w_fill) begin
            w_wr_en    = 1'b1;
            w_wr_dirty = 1'b0;
            w_wr_data  = mem_rdata;
        end else if (w_is_store &&
                     (((r_state == IDLE) && req_valid && w_hit) ||
                      (r_state == RESPOND))) begin
            w_wr_en = 1'b1;
        end
    end

    dcache_array #(
        .SETS    (SETS),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (w_index),
        .rd_valid (w_rd_valid),
        .rd_dirty (w_rd_dirty),
        .rd_tag   (w_rd_tag),
        .rd_data  (w_rd_data),
        .wr_en    (w_wr_en),
        .wr_index (w_index),
        .wr_tag   (w_tag),
        .wr_data  (w_wr_data),
        .wr_dirty (w_wr_dirty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_req_addr  <= '0;
            r_req_wtype <= WT_READ;
            r_req_wdata <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            cache_data  <= '0;
            line_out    <= '0;
            stall       <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_addr  <= req_addr;
                        r_req_wtype <= req_wtype;
                        r_req_wdata <= req_wdata;
                        if (w_hit) begin
                            resp_valid <= 1'b1;
                            cache_data <= w_merged;
                            line_out   <= w_offset;
                        end else begin
                            stall     <= 1'b1;
                            req_ready <= 1'b0;
                            mem_req   <= 1'b1;
                            if (w_rd_valid && w_rd_dirty) begin
                                r_state   <= WB;
                                mem_we    <= 1'b1;
                                mem_addr  <= {w_rd_tag, w_index, 2'b00};
                                mem_wdata <= w_rd_data;
                            end else begin
                                r_state  <= REFILL;
                                mem_we   <= 1'b0;
                                mem_addr <= {w_tag, w_index, 2'b00};
                            end
                        end
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        r_state  <= REFILL;
                        mem_we   <= 1'b0;
                        mem_addr <= {w_tag, w_index, 2'b00};
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        r_state <= mem_rvalid ? RESPOND : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_state <= RESPOND;
                    end
                end
                RESPOND: begin
                    resp_valid <= 1'b1;
                    cache_data <= w_merged;
                    line_out   <= w_offset;
                    stall      <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Self-checking bench for dcache_ctrl with a behavioural memory
//                and an architectural reference image of memory contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int ADDR_W = 32;
    localparam int SETS   = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [1:0]    req_wtype;
    logic [127:0]  req_wdata;
    logic          resp_valid;
    logic [127:0]  cache_data;
    logic [1:0]    line_out;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [127:0]  mem_rdata;

    always #5 clk = ~clk;

    dcache_ctrl #(.ADDR_W(ADDR_W), .SETS(SETS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wtype  (req_wtype),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .cache_data (cache_data),
        .line_out   (line_out),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int unsigned cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- reference image and backing memory ----------------
    logic [127:0] ref_mem   [int unsigned];
    logic [127:0] mem_model [int unsigned];

    function automatic logic [127:0] init_line(input int unsigned a);
        return {4{a ^ 32'h5A5A_0000}};
    endfunction

    function logic [127:0] get_ref(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    function logic [127:0] get_mem(input int unsigned a);
        return mem_model.exists(a) ? mem_model[a] : init_line(a);
    endfunction

    function automatic logic [127:0] ref_merge(input logic [127:0] l, input logic [127:0] d,
                                               input logic [1:0] wt, input logic [1:0] o);
        logic [127:0] m;
        logic [127:0] v;
        case (wt)
            2'b01:   begin m = 128'hFFFF_FFFF << (32 * o); v = {96'b0, d[31:0]} << (32 * o); end
            2'b10:   begin m = 128'hF_FFFF_FFFF << (64 * o[1]); v = {92'b0, d[35:0]} << (64 * o[1]); end
            2'b11:   begin m = '1; v = d; end
            default: begin m = '0; v = '0; end
        endcase
        return (l & ~m) | (v & m);
    endfunction

    // ---------------- memory responder ----------------
    int          ready_delay = 1;
    int          fill_delay  = 2;
    int          fill_count  = 0;
    int          wb_count    = 0;
    logic [31:0] last_fill_addr = '0;
    logic [31:0] last_wb_addr   = '0;
    logic [127:0] last_wb_data  = '0;
    int          wcnt       = 0;
    int          rv_cnt     = 0;
    bit          rv_pending = 1'b0;
    logic [127:0] rv_data   = '0;

    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst) begin
                wcnt       = 0;
                rv_pending = 1'b0;
            end else begin
                if (rv_pending) begin
                    if (rv_cnt <= 1) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rv_data;
                        rv_pending = 1'b0;
                    end else begin
                        rv_cnt--;
                    end
                end
                if (mem_req) begin
                    if (wcnt >= ready_delay) begin
                        mem_ready = 1'b1;
                        wcnt      = 0;
                        if (mem_we) begin
                            wb_count++;
                            last_wb_addr = mem_addr;
                            last_wb_data = mem_wdata;
                            mem_model[mem_addr] = mem_wdata;
                        end else begin
                            fill_count++;
                            last_fill_addr = mem_addr;
                            rv_data = get_mem(mem_addr);
                            if (fill_delay == 0) begin
                                mem_rvalid = 1'b1;
                                mem_rdata  = rv_data;
                            end else begin
                                rv_pending = 1'b1;
                                rv_cnt     = fill_delay;
                            end
                        end
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] data;
        logic [1:0]   off;
        int unsigned  t;
    } exp_t;

    exp_t         sb[$];
    int           n_resp        = 0;
    int unsigned  last_lat      = 0;
    logic [127:0] last_data     = '0;
    int           fills_at_resp = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && resp_valid === 1'b1) begin
                chk("resp_expected", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_data", cache_data, e.data);
                    chk("resp_line_out", line_out, e.off);
                    last_lat = cyc - e.t;
                end
                last_data     = cache_data;
                fills_at_resp = fill_count;
                n_resp++;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [1:0] wt, input logic [127:0] d);
        exp_t         e;
        int unsigned  la;
        logic [127:0] l;
        int           k;
        k = 0;
        while (req_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_wait", req_ready, 1'b1);
        la = {a[31:2], 2'b00};
        l  = ref_merge(get_ref(la), d, wt, a[1:0]);
        ref_mem[la] = l;
        e.data = l;
        e.off  = a[1:0];
        e.t    = cyc;
        sb.push_back(e);
        req_valid = 1'b1;
        req_addr  = a;
        req_wtype = wt;
        req_wdata = d;
        @(negedge clk);
    endtask

    task automatic wait_resps(input int target);
        int k;
        k = 0;
        while (n_resp < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("resp_timeout", (n_resp >= target), 1'b1);
    endtask

    int           fb;
    int           wb0;
    int           nr;
    int unsigned  t0;
    logic [127:0] wbexp;

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wtype = WT_READ;
        req_wdata = '0;
        ref_mem[32'h100]   = 128'hAAAA_AAAA_AAAA_AAAA_0003_0002_0001_0000;
        mem_model[32'h100] = 128'hAAAA_AAAA_AAAA_AAAA_0003_0002_0001_0000;
        ref_mem[32'h200]   = 128'h5555_5555_5555_5555_0203_0202_0201_0200;
        mem_model[32'h200] = 128'h5555_5555_5555_5555_0203_0202_0201_0200;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_flags", {resp_valid, stall, mem_req, mem_we}, 4'b0000);
        chk("rst_cache_data", cache_data, 128'h0);
        chk("rst_line_out", line_out, 2'b00);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        rst = 1'b1;
        @(negedge clk);

        // cold read: refill only
        fb = fill_count; wb0 = wb_count;
        issue(32'h100, WT_READ, '0);
        req_valid = 1'b0;
        chk("miss_stall_ready", {stall, req_ready}, 2'b10);
        wait_resps(1);
        chk("cold_fill_cnt", fill_count - fb, 1);
        chk("cold_no_wb", wb_count - wb0, 0);
        chk("cold_fill_addr", last_fill_addr, 32'h100);

        // back-to-back hits: read, 32-bit write, 36-bit write
        t0 = cyc;
        issue(32'h102, WT_READ, '0);
        issue(32'h101, WT_W32, 128'hDEAD_BEEF);
        issue(32'h103, WT_W36, 128'hF_1234_5678);
        req_valid = 1'b0;
        wait_resps(4);
        chk("hit_latency", last_lat, 1);
        chk("hit_burst_cycles", cyc - t0, 3);
        chk("w32_word1", last_data[63:32], 32'hDEAD_BEEF);
        chk("w36_low", last_data[99:64], 36'hF_1234_5678);
        chk("w36_upper_kept", last_data[127:100], 28'hAAA_AAAA);

        // dirty eviction with slow mem_ready
        ready_delay = 5;
        fb = fill_count; wb0 = wb_count;
        wbexp = get_ref(32'h100);
        issue(32'h200, WT_READ, '0);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("wb_hold_flags", {mem_req, mem_we, stall, req_ready}, 4'b1110);
            chk("wb_hold_addr", mem_addr, 32'h100);
            chk("wb_hold_data", mem_wdata, wbexp);
        end
        wait_resps(5);
        ready_delay = 1;
        chk("evict_wb_cnt", wb_count - wb0, 1);
        chk("evict_wb_addr", last_wb_addr, 32'h100);
        chk("evict_wb_data", last_wb_data, wbexp);
        chk("evict_fill_addr", last_fill_addr, 32'h200);

        // fill data arriving with the request handshake
        fill_delay = 0;
        wb0 = wb_count;
        issue(32'h100, WT_READ, '0);
        req_valid = 1'b0;
        wait_resps(6);
        chk("clean_victim_no_wb", wb_count - wb0, 0);
        fill_delay = 12;

        // reset while waiting for fill data
        fb = fill_count;
        issue(32'h300, WT_READ, '0);
        req_valid = 1'b0;
        for (int k = 0; k < 50 && fill_count == fb; k++) @(negedge clk);
        @(negedge clk);
        chk("pre_rst_stall", stall, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 1'b1);
        chk("mid_rst_flags", {resp_valid, stall, mem_req, mem_we}, 4'b0000);
        chk("mid_rst_cache_data", cache_data, 128'h0);
        chk("mid_rst_mem_addr", mem_addr, 32'h0);
        chk("mid_rst_mem_wdata", mem_wdata, 128'h0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // same address must miss again after reset
        fill_delay = 3;
        fb = fill_count; nr = n_resp;
        issue(32'h100, WT_READ, '0);
        req_valid = 1'b0;
        wait_resps(nr + 1);
        chk("post_rst_refill_first", fills_at_resp - fb, 1);

        // full-line store on a cold miss, then a hit on it
        issue(32'h105, WT_W128, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        req_valid = 1'b0;
        wait_resps(nr + 2);
        issue(32'h106, WT_READ, '0);
        req_valid = 1'b0;
        wait_resps(nr + 3);
        chk("w128_hit_latency", last_lat, 1);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
